// File: rtl/div_pipe.sv
// div_pipe: fully pipelined restoring divider, one op/clock, valid/ready with global stall.
// Signed mode (in_signed, sign fix-up, signed-overflow flag) is built only with DIV_PIPE_SIGNED_EN.

module div_stage #(
    parameter int DDW  = 16,
    parameter int DSW  = 8,
    parameter int BPS  = 1,
    parameter int MW   = 8,
    parameter bit ITER = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           vld,
    input  logic [DSW:0]   rem,
    input  logic [DDW-1:0] acc,
    input  logic [DSW-1:0] dsr,
    input  logic [MW-1:0]  meta,
    output logic           q_vld,
    output logic [DSW:0]   q_rem,
    output logic [DDW-1:0] q_acc,
    output logic [DSW-1:0] q_dsr,
    output logic [MW-1:0]  q_meta
);
    logic [DSW:0]   rem_nxt;
    logic [DDW-1:0] acc_nxt;

    // acc doubles as dividend and quotient: dividend bits leave at the top, quotient bits enter below
    always_comb begin
        rem_nxt = rem;
        acc_nxt = acc;
        if (ITER) begin
            for (int b = 0; b < BPS; b++) begin
                rem_nxt = {rem_nxt[DSW-1:0], acc_nxt[DDW-1]};
                acc_nxt = {acc_nxt[DDW-2:0], 1'b0};
                if (rem_nxt >= {1'b0, dsr}) begin
                    rem_nxt    = rem_nxt - {1'b0, dsr};
                    acc_nxt[0] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_vld  <= 1'b0;
            q_rem  <= '0;
            q_acc  <= '0;
            q_dsr  <= '0;
            q_meta <= '0;
        end else if (en) begin
            q_vld  <= vld;
            q_rem  <= rem_nxt;
            q_acc  <= acc_nxt;
            q_dsr  <= dsr;
            q_meta <= meta;
        end
    end
endmodule

module div_pipe #(
    parameter int DIVIDEND_WIDTH = 16,
    parameter int DIVISOR_WIDTH  = 8,
    parameter int BITS_PER_STAGE = 1,
    parameter int TAG_WIDTH      = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_signed,
    input  logic [DIVIDEND_WIDTH-1:0] dividend,
    input  logic [DIVISOR_WIDTH-1:0]  divisor,
    input  logic [TAG_WIDTH-1:0]      in_tag,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DIVIDEND_WIDTH-1:0] quotient,
    output logic [DIVISOR_WIDTH-1:0]  remainder,
    output logic                      overflow,
    output logic [TAG_WIDTH-1:0]      out_tag
);
    localparam int DDW    = DIVIDEND_WIDTH;
    localparam int DSW    = DIVISOR_WIDTH;
    localparam int N      = DDW / BITS_PER_STAGE;
    localparam int MW     = TAG_WIDTH + 4;
    localparam int M_QNEG = TAG_WIDTH;
    localparam int M_RNEG = TAG_WIDTH + 1;
    localparam int M_ZERO = TAG_WIDTH + 2;
    localparam int M_SOV  = TAG_WIDTH + 3;

    logic                   stall;
    logic [N:0]             vld_pipe;
    logic [N:0][DSW:0]      rem_pipe;
    logic [N:0][DDW-1:0]    acc_pipe;
    logic [N:0][DSW-1:0]    dsr_pipe;
    logic [N:0][MW-1:0]     meta_pipe;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    // operand conditioning: magnitudes are unsigned so the most negative value still fits
    logic [DDW-1:0] dd_mag;
    logic [DSW-1:0] ds_mag;
    logic           q_neg, r_neg, sov;
    logic [MW-1:0]  meta0;

`ifdef DIV_PIPE_SIGNED_EN
    logic dd_neg, ds_neg;
    always_comb begin
        dd_neg = in_signed & dividend[DDW-1];
        ds_neg = in_signed & divisor[DSW-1];
        dd_mag = dd_neg ? -dividend : dividend;
        ds_mag = ds_neg ? -divisor : divisor;
        q_neg  = dd_neg ^ ds_neg;
        r_neg  = dd_neg;
        sov    = in_signed && (dividend == {1'b1, {(DDW-1){1'b0}}}) && (&divisor);
    end
`else
    always_comb begin
        dd_mag = dividend;
        ds_mag = divisor;
        q_neg  = 1'b0;
        r_neg  = 1'b0;
        sov    = 1'b0;
    end
`endif

    assign meta0 = {sov, (divisor == '0), r_neg, q_neg, in_tag};

    for (genvar k = 0; k <= N; k++) begin : g_stg
        if (k == 0) begin : g_head
            div_stage #(.DDW(DDW), .DSW(DSW), .BPS(BITS_PER_STAGE), .MW(MW), .ITER(1'b0)) u_stg (
                .clk(clk), .rst_n(rst_n), .en(~stall),
                .vld(in_valid), .rem('0), .acc(dd_mag), .dsr(ds_mag), .meta(meta0),
                .q_vld(vld_pipe[k]), .q_rem(rem_pipe[k]), .q_acc(acc_pipe[k]),
                .q_dsr(dsr_pipe[k]), .q_meta(meta_pipe[k])
            );
        end else begin : g_iter
            div_stage #(.DDW(DDW), .DSW(DSW), .BPS(BITS_PER_STAGE), .MW(MW), .ITER(1'b1)) u_stg (
                .clk(clk), .rst_n(rst_n), .en(~stall),
                .vld(vld_pipe[k-1]), .rem(rem_pipe[k-1]), .acc(acc_pipe[k-1]),
                .dsr(dsr_pipe[k-1]), .meta(meta_pipe[k-1]),
                .q_vld(vld_pipe[k]), .q_rem(rem_pipe[k]), .q_acc(acc_pipe[k]),
                .q_dsr(dsr_pipe[k]), .q_meta(meta_pipe[k])
            );
        end
    end

    // fix-up: truncating division, remainder follows the dividend's sign
    logic [DDW-1:0] q_fix;
    logic [DSW-1:0] r_fix;
    logic           ovf_fix;

    always_comb begin
        q_fix   = acc_pipe[N];
        r_fix   = DSW'(rem_pipe[N]);
        ovf_fix = 1'b0;
`ifdef DIV_PIPE_SIGNED_EN
        if (meta_pipe[N][M_QNEG]) q_fix = -q_fix;
        if (meta_pipe[N][M_RNEG]) r_fix = -r_fix;
`endif
        if (meta_pipe[N][M_ZERO]) begin
            q_fix   = '1;
            r_fix   = '0;
            ovf_fix = 1'b1;
        end
`ifdef DIV_PIPE_SIGNED_EN
        else if (meta_pipe[N][M_SOV]) begin
            q_fix   = {1'b1, {(DDW-1){1'b0}}};
            r_fix   = '0;
            ovf_fix = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            overflow  <= 1'b0;
            out_tag   <= '0;
        end else if (!stall) begin
            out_valid <= vld_pipe[N];
            if (vld_pipe[N]) begin
                quotient  <= q_fix;
                remainder <= r_fix;
                overflow  <= ovf_fix;
                out_tag   <= meta_pipe[N][TAG_WIDTH-1:0];
            end
        end
    end
endmodule
